keycode_wavetable_mixer: RTL and testbench

//  Parametrised polyphonic wavetable mixer plus I2S transmitter. Maps NUM_VOICES keycode bytes to

---
 rtl/keycode_wavetable_mixer_if.sv | 19 +
 rtl/keycode_wavetable_mixer.sv | 205 ++++++++++++++++++++
 tb/tb_keycode_wavetable_mixer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/keycode_wavetable_mixer_if.sv
// Sample ROM bus between the wavetable mixer and the external single-port ROM.
// The ROM returns data one clock after it sees the address.
interface keycode_wavetable_mixer_if #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned SAMPLE_W = 8
) ();
  logic [ADDR_W-1:0]   rom_addr;
  logic [SAMPLE_W-1:0] rom_data;

  modport master (
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    output rom_data
  );
endinterface

// File: rtl/keycode_wavetable_mixer.sv
// Polyphonic wavetable mixer with an I2S transmitter.
// Each keycode byte selects a note (A4/C5/E5/A5) or silence. One sample per voice is read
// from the shared ROM, the voices are summed, and the mix is shifted out MSB first with the
// I2S one-bit delay on both channels.
// Build option SYNTH_SATURATE_EN: clamp the mix to the OUT_W range instead of wrapping it.
module keycode_wavetable_mixer #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned SAMPLE_W   = 8,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned OUT_W      = 10,
  parameter int unsigned FRAME_BITS = 32,
  parameter int unsigned LEN_A4     = 50,
  parameter int unsigned LEN_C5     = 42,
  parameter int unsigned LEN_E5     = 33,
  parameter int unsigned LEN_A5     = 25
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [8*NUM_VOICES-1:0] keycode_i,
  input  logic                    sclk_i,
  input  logic                    lrclk_i,
  input  logic [1:0]              rate_sel_i,
  keycode_wavetable_mixer_if.master rom_if,
  output logic [OUT_W-1:0]        mix_out_o,
  output logic                    mix_valid_o,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic                    i2s_dout_o
);

  localparam int unsigned AccW   = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int unsigned VoiceW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned WideW  = (AccW > OUT_W) ? AccW : OUT_W;

  typedef enum logic [1:0] {StIdle, StFetch, StWait, StDone} state_e;

  // Returns {active, note}; note 0..3 = A4, C5, E5, A5.
  function automatic logic [2:0] decode_key(input logic [7:0] kc);
    case (kc)
      8'd4:    return 3'b100;
      8'd6:    return 3'b101;
      8'd8:    return 3'b110;
      8'd34:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] note_base(input logic [1:0] n);
    case (n)
      2'd0:    return '0;
      2'd1:    return ADDR_W'(LEN_A4);
      2'd2:    return ADDR_W'(LEN_A4 + LEN_C5);
      default: return ADDR_W'(LEN_A4 + LEN_C5 + LEN_E5);
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] note_last(input logic [1:0] n);
    case (n)
      2'd0:    return ADDR_W'(LEN_A4 - 1);
      2'd1:    return ADDR_W'(LEN_C5 - 1);
      2'd2:    return ADDR_W'(LEN_E5 - 1);
      default: return ADDR_W'(LEN_A5 - 1);
    endcase
  endfunction

  function automatic logic [OUT_W-1:0] map_mix(input logic [AccW-1:0] acc);
    logic [WideW-1:0] wide;
    wide = WideW'(acc);
`ifdef SYNTH_SATURATE_EN
    if (wide > WideW'({OUT_W{1'b1}})) return '1;
`endif
    return wide[OUT_W-1:0];
  endfunction

  // [0] first sync stage, [1] synchronised copy, [2] previous synchronised value.
  logic [2:0] sclk_sync_q, lr_sync_q;
  logic       sclk_fall, lr_rise, lr_edge, tick;
  logic [1:0] dec_q, dec_d;

  state_e              state_q, state_d;
  logic [VoiceW-1:0]   v_q, v_d;
  logic [8*NUM_VOICES-1:0] kc_q, kc_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]   idx_q [4];
  logic [ADDR_W-1:0]   idx_d [4];
  logic [OUT_W-1:0]    mix_out_q, mix_out_d;
  logic                mix_valid_q, mix_valid_d;
  logic                overrun_q, overrun_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic [2:0]          voice_key, used_key;
  logic [3:0]          note_used;

  assign sclk_fall = sclk_sync_q[2] & ~sclk_sync_q[1];
  assign lr_rise   = lr_sync_q[1] & ~lr_sync_q[2];
  assign lr_edge   = lr_sync_q[1] ^ lr_sync_q[2];
  assign tick      = lr_rise & ((rate_sel_i == 2'b01) ||
                                ((rate_sel_i == 2'b10) ? (dec_q == 2'd3) : dec_q[0]));
  assign dec_d     = lr_rise ? dec_q + 2'd1 : dec_q;
  assign voice_key = decode_key(kc_q[8*v_q +: 8]);

  // Notes referenced by at least one latched voice; these advance once per mix.
  always_comb begin
    note_used = '0;
    used_key  = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      used_key = decode_key(kc_q[8*v +: 8]);
      if (used_key[2]) note_used[used_key[1:0]] = 1'b1;
    end
  end

  // Voice sequencer: fetch/accumulate one voice per two cycles, then publish and step indices.
  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    kc_d        = kc_q;
    acc_d       = acc_q;
    rom_addr_d  = rom_addr_q;
    mix_out_d   = mix_out_q;
    mix_valid_d = 1'b0;
    overrun_d   = overrun_q | (tick & (state_q != StIdle));
    for (int n = 0; n < 4; n++) idx_d[n] = idx_q[n];
    case (state_q)
      StIdle: begin
        if (tick) begin
          kc_d    = keycode_i;
          acc_d   = '0;
          v_d     = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // Silent voices leave the ROM address where it was.
        if (voice_key[2]) rom_addr_d = note_base(voice_key[1:0]) + idx_q[voice_key[1:0]];
        state_d = StWait;
      end
      StWait: begin
        if (voice_key[2]) acc_d = acc_q + AccW'(rom_if.rom_data);
        if (v_q == VoiceW'(NUM_VOICES - 1)) begin
          // Publish here so mix_valid lands in the DONE cycle, 2*NUM_VOICES+1 after the tick.
          mix_out_d   = map_mix(acc_d);
          mix_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          v_d     = v_q + 1'b1;
          state_d = StFetch;
        end
      end
      default: begin
        for (int n = 0; n < 4; n++) begin
          if (note_used[n]) idx_d[n] = (idx_q[n] == note_last(2'(n))) ? '0 : idx_q[n] + 1'b1;
        end
        state_d = StIdle;
      end
    endcase
  end

  // Serialiser: an lrclk edge reloads the frame and takes priority over an sclk shift.
  always_comb begin
    sh_d = sh_q;
    if (lr_edge) sh_d = FRAME_BITS'({1'b0, mix_out_q}) << (FRAME_BITS - 1 - OUT_W);
    else if (sclk_fall) sh_d = sh_q << 1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sclk_sync_q <= '0;
      lr_sync_q   <= '0;
      dec_q       <= '0;
      state_q     <= StIdle;
      v_q         <= '0;
      kc_q        <= '0;
      acc_q       <= '0;
      rom_addr_q  <= '0;
      for (int n = 0; n < 4; n++) idx_q[n] <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      sh_q        <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk_i};
      lr_sync_q   <= {lr_sync_q[1:0], lrclk_i};
      dec_q       <= dec_d;
      state_q     <= state_d;
      v_q         <= v_d;
      kc_q        <= kc_d;
      acc_q       <= acc_d;
      rom_addr_q  <= rom_addr_d;
      for (int n = 0; n < 4; n++) idx_q[n] <= idx_d[n];
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      overrun_q   <= overrun_d;
      sh_q        <= sh_d;
    end
  end

  assign rom_if.rom_addr = rom_addr_d;
  assign mix_out_o       = mix_out_q;
  assign mix_valid_o     = mix_valid_q;
  assign busy_o          = (state_q != StIdle);
  assign overrun_o       = overrun_q;
  assign i2s_dout_o      = sh_q[FRAME_BITS-1];

endmodule

// File: tb/tb_keycode_wavetable_mixer.sv
// Directed bench for keycode_wavetable_mixer. A second instance with OUT_W=9 and an all-0xFF
// ROM checks the wrap/saturate mapping for whichever SYNTH_SATURATE_EN setting is compiled.
module tb_keycode_wavetable_mixer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] keycode = '0;
  logic        sclk = 1'b0;
  logic        lrclk = 1'b0;
  logic [1:0]  rate_sel = 2'b01;
  logic [9:0]  mix_out;
  logic        mix_valid, busy, overrun, i2s_dout;
  logic [8:0]  mix9;
  logic        valid9, busy9, overrun9, dout9;
  int          rom_mode = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          valid_cnt = 0;

  // Wrap: 1020 mod 512; saturate: 511.
`ifdef SYNTH_SATURATE_EN
  localparam logic [31:0] Exp9 = 32'd511;
`else
  localparam logic [31:0] Exp9 = 32'd508;
`endif

  keycode_wavetable_mixer_if #(.ADDR_W(8), .SAMPLE_W(8)) rom_if ();
  keycode_wavetable_mixer_if #(.ADDR_W(8), .SAMPLE_W(8)) rom9_if ();

  keycode_wavetable_mixer dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .keycode_i   (keycode),
    .sclk_i      (sclk),
    .lrclk_i     (lrclk),
    .rate_sel_i  (rate_sel),
    .rom_if      (rom_if.master),
    .mix_out_o   (mix_out),
    .mix_valid_o (mix_valid),
    .busy_o      (busy),
    .overrun_o   (overrun),
    .i2s_dout_o  (i2s_dout)
  );

  keycode_wavetable_mixer #(.OUT_W(9)) dut9 (
    .clk_i       (clk),
    .reset_i     (reset),
    .keycode_i   (32'h0406_0822),
    .sclk_i      (sclk),
    .lrclk_i     (lrclk),
    .rate_sel_i  (rate_sel),
    .rom_if      (rom9_if.master),
    .mix_out_o   (mix9),
    .mix_valid_o (valid9),
    .busy_o      (busy9),
    .overrun_o   (overrun9),
    .i2s_dout_o  (dout9)
  );

  always #5 clk = ~clk;

  // ROM models: one-cycle read latency.
  always @(posedge clk) begin
    if (rom_mode == 0) rom_if.rom_data <= rom_if.rom_addr;
    else rom_if.rom_data <= (rom_if.rom_addr < 8'd50) ? 8'd255 : 8'd173;
    rom9_if.rom_data <= 8'hFF;
  end

  always @(posedge clk) if (mix_valid) valid_cnt <= valid_cnt + 1;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2);
  endtask

  // lrclk rise, expect mix_valid 11 negedges later (2 sync stages + 9), then lrclk fall.
  task automatic do_tick(input string tag, input logic [31:0] exp);
    int lat;
    lat = 0;
    lrclk = 1'b1;
    while (!mix_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 11);
    check({tag, "_mix"}, 32'(mix_out), exp);
    lrclk = 1'b0;
    wait_clk(4);
  endtask

  task automatic check_frame(input string tag);
    logic [31:0] frame;
    frame = 32'h5560_0000;  // {0, 10'h2AB, 21'b0}
    for (int k = 0; k < 32; k++) begin
      check(tag, 32'(i2s_dout), 32'(frame[31-k]));
      sclk = 1'b1;
      wait_clk(3);
      sclk = 1'b0;
      wait_clk(4);
    end
  endtask

  initial begin
    int vc;
    wait_clk(4);
    check("rst_busy", 32'(busy), 0);
    check("rst_mix", 32'(mix_out), 0);
    check("rst_valid", 32'(mix_valid), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_dout", 32'(i2s_dout), 0);
    reset = 1'b0;
    wait_clk(2);

    // Single A4 voice, ROM=addr: mix follows the A4 index, wrapping after 49.
    keycode = 32'h0000_0004;
    rate_sel = 2'b01;
    for (int i = 0; i < 51; i++) begin
      do_tick("a4_walk", 32'(i % 50));
      if (i == 0) check("out9_map", 32'(mix9), Exp9);
    end

    // Duplicate A4: sample counted twice, index advances once per tick.
    do_reset();
    keycode = 32'h0000_0404;
    for (int i = 0; i < 4; i++) do_tick("dup_a4", 32'(2 * i));

    // All four notes: 0+50+92+125, then each index +1.
    do_reset();
    keycode = 32'h0406_0822;
    do_tick("chord0", 32'd267);
    do_tick("chord1", 32'd271);

    // Decimate by 4: 40 lrclk rises give 10 mixes and no overrun.
    do_reset();
    keycode = 32'h0000_0004;
    rate_sel = 2'b10;
    vc = valid_cnt;
    for (int i = 0; i < 40; i++) begin
      lrclk = 1'b1;
      wait_clk(6);
      lrclk = 1'b0;
      wait_clk(6);
    end
    wait_clk(15);
    check("dec4_count", 32'(valid_cnt - vc), 10);
    check("dec4_overrun", 32'(overrun), 0);

    // Second tick lands mid-mix: ignored but flagged.
    do_reset();
    rate_sel = 2'b01;
    vc = valid_cnt;
    lrclk = 1'b1;
    wait_clk(3);
    lrclk = 1'b0;
    wait_clk(3);
    lrclk = 1'b1;
    wait_clk(3);
    lrclk = 1'b0;
    wait_clk(20);
    check("ovr_flag", 32'(overrun), 1);
    check("ovr_count", 32'(valid_cnt - vc), 1);

    // Serialiser: mix 0x2AB = 255+255+173, frame on the lrclk fall and the next rise.
    do_reset();
    rom_mode = 1;
    keycode = 32'h0006_0404;
    do_tick("ser_mix", 32'h2AB);
    check_frame("ser_fall");
    lrclk = 1'b1;
    wait_clk(4);
    check_frame("ser_rise");
    lrclk = 1'b0;
    wait_clk(12);

    // Reset during WAIT of voice 2 aborts the mix and zeroes the note indices.
    do_reset();
    rom_mode = 0;
    keycode = 32'h0000_0022;
    do_tick("a5_pre0", 32'd125);
    do_tick("a5_pre1", 32'd126);
    do_tick("a5_pre2", 32'd127);
    lrclk = 1'b1;
    wait_clk(8);
    check("abort_busy_pre", 32'(busy), 1);
    vc = valid_cnt;
    reset = 1'b1;
    lrclk = 1'b0;
    wait_clk(1);
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(mix_valid), 0);
    check("abort_mix", 32'(mix_out), 0);
    check("abort_dout", 32'(i2s_dout), 0);
    wait_clk(1);
    reset = 1'b0;
    wait_clk(10);
    check("abort_no_valid", 32'(valid_cnt - vc), 0);
    do_tick("a5_post0", 32'd125);
    do_tick("a5_post1", 32'd126);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
